alu_issue_unit: RTL

Sequential initiator that drives the combinational ALU. It accepts operation requests over a valid/ready handshake and registers the operands and opcode onto the ALU input ports. It captures the ALU result and flags one cycle later and holds the response until the consumer accepts it. It also keeps a sticky flag register and supports result chaining, so later ops can use the previous result as operand a.

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_issue_unit_if.sv | 29 ++
 rtl/alu_issue_unit.sv | 97 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue unit and the combinational ALU it drives:
// opcodes, CMP modifiers, flag bit positions and the issue FSM encoding.
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_MUL  = 5'd2;
  localparam logic [4:0] OP_DIV  = 5'd3;
  localparam logic [4:0] OP_CMP  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_XOR  = 5'd7;
  localparam logic [4:0] OP_NOT  = 5'd8;
  localparam logic [4:0] OP_NAND = 5'd9;
  localparam logic [4:0] OP_NOR  = 5'd10;
  localparam logic [4:0] OP_XNOR = 5'd11;
  localparam logic [4:0] OP_SHR  = 5'd13;
  localparam logic [4:0] OP_SHL  = 5'd14;

  // Modifier field lives in op[7:5]
  localparam logic [2:0] CMP_GT = 3'b001;
  localparam logic [2:0] CMP_LT = 3'b010;
  localparam logic [2:0] CMP_EQ = 3'b100;
  localparam logic [2:0] CMP_GE = 3'b101;
  localparam logic [2:0] CMP_LE = 3'b110;
  localparam int         ROTATE_BIT = 5;

  localparam int FLAG_OVF  = 0;
  localparam int FLAG_UNF  = 1;
  localparam int FLAG_GT   = 2;
  localparam int FLAG_EQ   = 3;
  localparam int FLAG_DIV0 = 4;
  localparam int FLAG_UNKN = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } issue_state_e;

endpackage

// File: rtl/alu_issue_unit_if.sv
// Request/response bundle between an op producer/consumer and the issue unit.
//
// Handshake: a request transfers on a rising edge where req_valid & req_ready;
// a response transfers where rsp_valid & rsp_ready. A producer holding valid
// keeps its payload stable until the transfer; rsp payload is stable while
// rsp_valid is high and not yet accepted.
interface alu_issue_unit_if #(parameter int BITS = 8);
  logic            req_valid;
  logic            req_ready;
  logic [BITS-1:0] req_op;
  logic [BITS-1:0] req_a;
  logic [BITS-1:0] req_b;
  logic            req_chain;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [BITS-1:0] rsp_z;
  logic [7:0]      rsp_flags;
  logic            rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, req_chain, rsp_ready,
    input  req_ready, rsp_valid, rsp_z, rsp_flags, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_chain, rsp_ready,
    output req_ready, rsp_valid, rsp_z, rsp_flags, rsp_err
  );
endinterface

// File: rtl/alu_issue_unit.sv
// Issues one op at a time to an external combinational ALU, registers its
// result one cycle later and holds it until the consumer takes it.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int BITS      = 8,
  parameter int LOG2_BITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_issue_unit_if.slave     bus,
  input  logic                flag_clr,
  output logic [7:0]          sticky_flags,
  output logic                busy,
  output issue_state_e        dbg_state,
  output logic [BITS-1:0]     alu_a,
  output logic [BITS-1:0]     alu_b,
  output logic [BITS-1:0]     alu_op,
  input  logic [BITS-1:0]     alu_z,
  input  logic [7:0]          alu_flags
);

  issue_state_e    state_q, state_d;
  logic [BITS-1:0] alu_a_q, alu_b_q, alu_op_q;
  logic [BITS-1:0] rsp_z_q, last_z_q;
  logic [7:0]      rsp_flags_q, sticky_q, sticky_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            req_ready, accept, capture;

  always_comb begin
    req_ready   = (state_q == ST_IDLE) || (state_q == ST_DONE && bus.rsp_ready);
    accept      = bus.req_valid && req_ready;
    capture     = (state_q == ST_EXEC);
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: begin
        state_d     = ST_DONE;
        rsp_valid_d = 1'b1;
      end
      ST_DONE: if (bus.rsp_ready) begin
        state_d     = accept ? ST_EXEC : ST_IDLE;
        rsp_valid_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Flags captured this cycle survive a clear raised in the same cycle.
  always_comb begin
    sticky_d = sticky_q;
    if (capture)       sticky_d = (flag_clr ? 8'h00 : sticky_q) | alu_flags;
    else if (flag_clr) sticky_d = 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_z_q     <= '0;
      rsp_flags_q <= '0;
      rsp_valid_q <= 1'b0;
      last_z_q    <= '0;
      sticky_q    <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      sticky_q    <= sticky_d;
      if (accept) begin
        alu_a_q  <= bus.req_chain ? last_z_q : bus.req_a;
        alu_b_q  <= bus.req_b;
        alu_op_q <= bus.req_op;
      end
      if (capture) begin
        rsp_z_q     <= alu_z;
        rsp_flags_q <= alu_flags;
        last_z_q    <= alu_z;
      end
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_z     = rsp_z_q;
  assign bus.rsp_flags = rsp_flags_q;
  assign bus.rsp_err   = rsp_flags_q[FLAG_DIV0] | rsp_flags_q[FLAG_UNKN];
  assign sticky_flags  = sticky_q;
  assign busy          = (state_q != ST_IDLE);
  assign dbg_state     = state_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_op        = alu_op_q;

endmodule
